// File: rtl/button_event_classifier.sv
// Classifies a debounced button level into press/release, short, long and
// double-click events using one FSM and a single shared cycle counter.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | button up, no classification pending
// PRESSED  | first press in progress, counting towards a long press
// WAIT2    | first press released, counting the gap for a second press
// PRESSED2 | second press in progress, counting towards a long press
// LONG     | long press reported, waiting for the release
module button_event_classifier #(
  parameter int unsigned LONG_CYCLES   = 1000,
  parameter int unsigned DCLICK_CYCLES = 250,
  parameter int unsigned CNT_W         = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clean_in,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic held
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESSED  = 3'd1,
    WAIT2    = 3'd2,
    PRESSED2 = 3'd3,
    LONG     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] DCLICK_TC = CNT_W'(DCLICK_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             in_d;
  logic             rise;
  logic             fall;

  assign rise = clean_in & ~in_d;
  assign fall = ~clean_in & in_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      in_d          <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      double_click  <= 1'b0;
      held          <= 1'b0;
    end else begin
      in_d          <= clean_in;
      press_pulse   <= rise;
      release_pulse <= fall;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      double_click  <= 1'b0;
      // held follows the state one cycle late, so it is sampled pre-update
      held          <= (state == PRESSED) || (state == PRESSED2) || (state == LONG);

      // Edges win over terminal counts: a release on the last count is short,
      // a re-press on the last gap cycle is still a double click.
      case (state)
        IDLE: begin
          if (rise) begin
            state <= PRESSED;
            cnt   <= '0;
          end
        end
        PRESSED: begin
          if (fall) begin
            state <= WAIT2;
            cnt   <= '0;
          end else if (cnt == LONG_TC) begin
            state      <= LONG;
            long_press <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT2: begin
          if (rise) begin
            state <= PRESSED2;
            cnt   <= '0;
          end else if (cnt == DCLICK_TC) begin
            state       <= IDLE;
            short_press <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED2: begin
          if (fall) begin
            state        <= IDLE;
            double_click <= 1'b1;
          end else if (cnt == LONG_TC) begin
            state      <= LONG;
            long_press <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LONG: begin
          if (fall) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
